riscv_multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle RV32I subset core: LW, SW, ADDI-class I-type, R-type ALU ops, and BEQ. It reads the opcode from the instruction register and sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch, decode, execute, memory and writeback. It also handles the memory ready handshake, flags illegal opcodes and counts retired instructions. The immediate generator consumes the same IR opcode in parallel; this block only selects when that immediate is used.

---
 rtl/riscv_multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - main control FSM for the multi-cycle RV32I subset core
module riscv_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal_instr,
  output logic [3:0]  state,
  output logic [31:0] instr_retired
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_q, state_d;
  logic   retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RESET;
      instr_retired <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) instr_retired <= instr_retired + 32'd1;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 is written back in the same cycle the instruction word lands in IR
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - directed self-checking bench for riscv_multicycle_ctrl
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic        reg_write, mem_to_reg, illegal_instr;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .illegal_instr(illegal_instr), .state(state), .instr_retired(instr_retired)
  );

  task automatic test_reset();
    reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_checks++; if (instr_retired !== 32'd0) $display("FAIL reset_count got %0d want 0", instr_retired); else n_pass++;
    n_checks++; if ({mem_req, ir_write, pc_write, reg_write} !== 4'b0000)
      $display("FAIL reset_outputs got %b want 0000", {mem_req, ir_write, pc_write, reg_write}); else n_pass++;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (state !== 4'd1) $display("FAIL reset_first_fetch got %0d want 1", state); else n_pass++;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL fetch_mem_req got %b want 1", mem_req); else n_pass++;
  endtask

  task automatic test_addi();
    int exp_st[5] = '{1, 2, 8, 9, 1};
    opcode = 7'h13; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (state !== exp_st[i][3:0]) $display("FAIL addi_state[%0d] got %0d want %0d", i, state, exp_st[i]); else n_pass++;
      n_checks++; if (reg_write !== (exp_st[i] == 9)) $display("FAIL addi_reg_write[%0d] got %b want %b", i, reg_write, exp_st[i] == 9); else n_pass++;
      n_checks++; if (instr_retired !== ((i == 4) ? 32'd1 : 32'd0))
        $display("FAIL addi_count[%0d] got %0d want %0d", i, instr_retired, (i == 4) ? 1 : 0); else n_pass++;
      if (exp_st[i] == 8) begin
        n_checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b01_10_11)
          $display("FAIL addi_exec_ctrl got %b want 011011", {alu_src_a, alu_src_b, alu_op}); else n_pass++;
      end
      if (exp_st[i] == 2) begin
        n_checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_10_00)
          $display("FAIL decode_ctrl got %b want 101000", {alu_src_a, alu_src_b, alu_op}); else n_pass++;
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_lw();
    int exp_st[9] = '{1, 1, 1, 2, 3, 4, 4, 4, 5};
    int mr[9]     = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
    int irw = 0;
    int wb  = 0;
    opcode = 7'h03;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i][0];
      #1;
      n_checks++; if (state !== exp_st[i][3:0]) $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp_st[i]); else n_pass++;
      if (exp_st[i] == 4) begin
        n_checks++; if ({mem_req, iord, mem_we} !== 3'b110) $display("FAIL lw_read_ctrl[%0d] got %b want 110", i, {mem_req, iord, mem_we}); else n_pass++;
      end
      if (ir_write) irw++;
      if (reg_write && mem_to_reg) wb++;
      @(posedge clk); #1;
    end
    n_checks++; if (state !== 4'd1) $display("FAIL lw_done_state got %0d want 1", state); else n_pass++;
    n_checks++; if (irw !== 1) $display("FAIL lw_ir_write_pulses got %0d want 1", irw); else n_pass++;
    n_checks++; if (wb !== 1) $display("FAIL lw_mem_wb_cycles got %0d want 1", wb); else n_pass++;
    n_checks++; if (instr_retired !== 32'd2) $display("FAIL lw_count got %0d want 2", instr_retired); else n_pass++;
  endtask

  task automatic test_beq(input logic z, input int exp_cnt);
    int exp_st[3] = '{1, 2, 10};
    opcode = 7'h63; mem_ready = 1'b1; zero = z;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (state !== exp_st[i][3:0]) $display("FAIL beq%0d_state[%0d] got %0d want %0d", z, i, state, exp_st[i]); else n_pass++;
      if (exp_st[i] == 10) begin
        n_checks++; if (pc_write !== z) $display("FAIL beq%0d_pc_write got %b want %b", z, pc_write, z); else n_pass++;
        n_checks++; if (pc_src !== 1'b1) $display("FAIL beq%0d_pc_src got %b want 1", z, pc_src); else n_pass++;
        n_checks++; if (alu_op !== 2'b01) $display("FAIL beq%0d_alu_op got %b want 01", z, alu_op); else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (state !== 4'd1) $display("FAIL beq%0d_done_state got %0d want 1", z, state); else n_pass++;
    n_checks++; if (instr_retired !== exp_cnt[31:0]) $display("FAIL beq%0d_count got %0d want %0d", z, instr_retired, exp_cnt); else n_pass++;
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    int exp_st[3] = '{1, 2, 11};
    int pulses = 0;
    opcode = 7'h7F; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (state !== exp_st[i][3:0]) $display("FAIL illegal_state[%0d] got %0d want %0d", i, state, exp_st[i]); else n_pass++;
      if (illegal_instr) pulses++;
      @(posedge clk); #1;
    end
    n_checks++; if (pulses !== 1) $display("FAIL illegal_pulses got %0d want 1", pulses); else n_pass++;
    n_checks++; if (state !== 4'd1) $display("FAIL illegal_next got %0d want 1", state); else n_pass++;
    n_checks++; if (instr_retired !== 32'd4) $display("FAIL illegal_count got %0d want 4", instr_retired); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int exp_st[4] = '{1, 2, 3, 6};
    int mr[4]     = '{1, 1, 1, 0};
    opcode = 7'h23;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i][0];
      #1;
      n_checks++; if (state !== exp_st[i][3:0]) $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp_st[i]); else n_pass++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    n_checks++; if ({mem_req, mem_we, iord} !== 3'b111) $display("FAIL sw_write_ctrl got %b want 111", {mem_req, mem_we, iord}); else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_checks++; if ({mem_req, mem_we} !== 2'b00) $display("FAIL async_reset_req got %b want 00", {mem_req, mem_we}); else n_pass++;
    n_checks++; if (state !== 4'd0) $display("FAIL async_reset_state got %0d want 0", state); else n_pass++;
    n_checks++; if (instr_retired !== 32'd0) $display("FAIL async_reset_count got %0d want 0", instr_retired); else n_pass++;
    @(posedge clk); #2 reset = 1'b0;
    #1;
    n_checks++; if (state !== 4'd0) $display("FAIL post_release_state got %0d want 0", state); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (state !== 4'd1) $display("FAIL post_release_fetch got %0d want 1", state); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_st[4] = '{1, 2, 3, 6};
    int we_in_fetch = 0;
    int st_errs = 0;
    opcode = 7'h23; mem_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) begin
        #1;
        if (state !== exp_st[i][3:0]) st_errs++;
        if (state == 4'd1 && mem_we) we_in_fetch++;
        @(posedge clk); #1;
      end
    end
    n_checks++; if (st_errs !== 0) $display("FAIL b2b_state_seq got %0d bad cycles want 0", st_errs); else n_pass++;
    n_checks++; if (we_in_fetch !== 0) $display("FAIL b2b_we_in_fetch got %0d want 0", we_in_fetch); else n_pass++;
    n_checks++; if (instr_retired !== 32'd4) $display("FAIL b2b_count got %0d want 4", instr_retired); else n_pass++;
    n_checks++; if (state !== 4'd1) $display("FAIL b2b_done_state got %0d want 1", state); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_beq(1'b1, 3);
    test_beq(1'b0, 4);
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
